// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard scoreboard: per-register latency countdowns drive stall/flush/freeze
// controls, with deferred mispredict flush, sticky halt and a saturating stall counter.
module hazard_scoreboard_unit #(
  parameter int REG_W   = 5,
  parameter int MAX_LAT = 3,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 32,
  localparam int LAT_W  = $clog2(MAX_LAT + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_wen,
  input  logic [REG_W-1:0] id_rd,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             mispredict,
  input  logic             dmem_wait,
  input  logic             halt,
  output logic             pc_wen,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int NREG = 2 ** REG_W;
  // Largest counter value whose result is already obtainable (register file or bypass).
  localparam logic [LAT_W-1:0] READY_MAX = (FWD_EN != 0) ? LAT_W'(1) : LAT_W'(0);

  logic [LAT_W-1:0] cnt_r [NREG];
  logic             pend_flush_r;
  logic             halted_r;
  logic [CNT_W-1:0] stall_count_r;

  logic flush_now_s;
  logic frozen_s;
  logic hz_s;
  logic issue_s;

  function automatic logic busy(input logic [REG_W-1:0] r, input logic [LAT_W-1:0] c);
    return (r != REG_W'(0)) && (c > READY_MAX);
  endfunction

  // Hazard detection on the ID instruction's source operands
  always_comb begin
    flush_now_s = mispredict | pend_flush_r;
    frozen_s    = halted_r | dmem_wait;
    hz_s        = id_valid & ~flush_now_s &
                  (busy(id_rs, cnt_r[id_rs]) | (id_uses_rt & busy(id_rt, cnt_r[id_rt])));
  end

  // Prioritised pipeline control outputs; issue only happens on a fully clean cycle
  always_comb begin
    pc_wen     = 1'b1;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    freeze     = 1'b0;
    issue_s    = 1'b0;
    if (halted_r) begin
      pc_wen = 1'b0;
      freeze = 1'b1;
    end else if (dmem_wait) begin
      pc_wen = 1'b0;
      freeze = 1'b1;
    end else if (flush_now_s) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (hz_s) begin
      pc_wen     = 1'b0;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end else begin
      issue_s = id_valid & id_wen & (id_rd != REG_W'(0));
    end
  end

  // Per-register latency counters: reissue overrides the countdown
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) cnt_r[r] <= LAT_W'(0);
    end else if (!frozen_s) begin
      for (int r = 0; r < NREG; r++) begin
        if (issue_s && (id_rd == REG_W'(r))) begin
          cnt_r[r] <= id_lat;
        end else if (cnt_r[r] != LAT_W'(0)) begin
          cnt_r[r] <= cnt_r[r] - LAT_W'(1);
        end else begin
          cnt_r[r] <= cnt_r[r];
        end
      end
    end else begin
      for (int r = 0; r < NREG; r++) cnt_r[r] <= cnt_r[r];
    end
  end

  // Mispredicts seen under a memory freeze are held until the pipeline moves again
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_flush_r <= 1'b0;
    end else if (!frozen_s) begin
      pend_flush_r <= 1'b0;
    end else if (!halted_r && mispredict) begin
      pend_flush_r <= 1'b1;
    end else begin
      pend_flush_r <= pend_flush_r;
    end
  end

  // Sticky halt, cleared only by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halted_r <= 1'b0;
    end else if (halt) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  // Saturating count of stalled or frozen cycles, not counting the halted state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_count_r <= CNT_W'(0);
    end else if ((freeze | stall_ifid) & ~halted_r & ~(&stall_count_r)) begin
      stall_count_r <= stall_count_r + CNT_W'(1);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign halted      = halted_r;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: two instances (forwarding with a 4-bit
// counter, and no forwarding with a 32-bit counter) share one stimulus stream.
module tb_hazard_scoreboard_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       id_valid, id_uses_rt, id_wen, mispredict, dmem_wait, halt;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [1:0] id_lat;

  logic        a_pc_wen, a_stall_ifid, a_flush_ifid, a_flush_idex, a_freeze, a_halted;
  logic [3:0]  a_stall_count;
  logic        b_pc_wen, b_stall_ifid, b_flush_ifid, b_flush_idex, b_freeze, b_halted;
  logic [31:0] b_stall_count;

  // ctrl vector = {pc_wen, stall_ifid, flush_ifid, flush_idex, freeze, halted}
  localparam logic [31:0] IDLE   = 32'b100000;
  localparam logic [31:0] STALL  = 32'b010100;
  localparam logic [31:0] FLUSH  = 32'b101100;
  localparam logic [31:0] FREEZE = 32'b000010;
  localparam logic [31:0] HALTED = 32'b000011;

  localparam int K_CA = 0, K_SA = 1, K_CB = 2, K_SB = 3;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  hazard_scoreboard_unit #(.REG_W(5), .MAX_LAT(3), .FWD_EN(1), .CNT_W(4)) dut_a (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_wen(id_wen), .id_rd(id_rd), .id_lat(id_lat),
    .mispredict(mispredict), .dmem_wait(dmem_wait), .halt(halt),
    .pc_wen(a_pc_wen), .stall_ifid(a_stall_ifid), .flush_ifid(a_flush_ifid),
    .flush_idex(a_flush_idex), .freeze(a_freeze), .halted(a_halted),
    .stall_count(a_stall_count)
  );

  hazard_scoreboard_unit #(.REG_W(5), .MAX_LAT(3), .FWD_EN(0), .CNT_W(32)) dut_b (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_wen(id_wen), .id_rd(id_rd), .id_lat(id_lat),
    .mispredict(mispredict), .dmem_wait(dmem_wait), .halt(halt),
    .pc_wen(b_pc_wen), .stall_ifid(b_stall_ifid), .flush_ifid(b_flush_ifid),
    .flush_idex(b_flush_idex), .freeze(b_freeze), .halted(b_halted),
    .stall_count(b_stall_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_CA:    return {26'd0, a_pc_wen, a_stall_ifid, a_flush_ifid, a_flush_idex, a_freeze, a_halted};
      K_SA:    return {28'd0, a_stall_count};
      K_CB:    return {26'd0, b_pc_wen, b_stall_ifid, b_flush_ifid, b_flush_idex, b_freeze, b_halted};
      K_SB:    return b_stall_count;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  // Compare every queued expectation against the DUT on the falling edge
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    @(negedge CLK);
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.kind);
      chk_cnt = chk_cnt + 1;
      assert (obs === e.val) pass_cnt = pass_cnt + 1;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_id(input int v, input int rs, input int rt, input int ur,
                        input int we, input int rd, input int lat);
    id_valid   = 1'(v);
    id_rs      = 5'(rs);
    id_rt      = 5'(rt);
    id_uses_rt = 1'(ur);
    id_wen     = 1'(we);
    id_rd      = 5'(rd);
    id_lat     = 2'(lat);
  endtask

  initial begin
    RST = 1'b1;
    mispredict = 1'b0;
    dmem_wait  = 1'b0;
    halt       = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    push("reset_ctrl_a", K_CA, IDLE);
    push("reset_cnt_a", K_SA, 32'd0);
    push("reset_ctrl_b", K_CB, IDLE);
    drain();
    cyc(); RST = 1'b0;

    // load rd=5 lat=2 followed by a reader of r5
    cyc(); set_id(1, 1, 2, 0, 1, 5, 2);
    push("ld_issue_a", K_CA, IDLE); drain();
    cyc(); set_id(1, 5, 0, 0, 1, 6, 1);
    push("ld_use_stall_a", K_CA, STALL); push("ld_use_stall_b", K_CB, STALL); drain();
    cyc();
    push("ld_use_go_a", K_CA, IDLE); push("ld_use_cnt_a", K_SA, 32'd1);
    push("ld_use_still_b", K_CB, STALL); drain();
    cyc(); set_id(0, 0, 0, 0, 0, 0, 0);
    push("ld_idle_cnt_a", K_SA, 32'd1); push("ld_idle_cnt_b", K_SB, 32'd2); drain();

    // latency 3, rt dependency, no forwarding on dut_b
    cyc(); set_id(1, 0, 0, 0, 1, 7, 3);
    push("l3_issue_b", K_CB, IDLE); drain();
    cyc(); set_id(1, 0, 7, 1, 0, 0, 1);
    push("l3_stall1_b", K_CB, STALL); push("l3_stall1_a", K_CA, STALL); drain();
    cyc(); push("l3_stall2_b", K_CB, STALL); push("l3_stall2_a", K_CA, STALL); drain();
    cyc(); push("l3_stall3_b", K_CB, STALL); push("l3_fwd_a", K_CA, IDLE); drain();
    cyc(); push("l3_go_b", K_CB, IDLE);
    push("l3_cnt_b", K_SB, 32'd5); push("l3_cnt_a", K_SA, 32'd3); drain();
    cyc(); set_id(1, 0, 0, 0, 1, 7, 3);
    drain();
    cyc(); set_id(1, 0, 7, 0, 0, 0, 1);
    push("l3_no_rt_b", K_CB, IDLE); drain();

    // register 0 is never tracked
    cyc(); set_id(1, 0, 0, 0, 1, 0, 3);
    drain();
    cyc(); set_id(1, 0, 0, 1, 0, 0, 1);
    push("r0_no_stall_b", K_CB, IDLE); push("r0_no_stall_a", K_CA, IDLE); drain();

    // reissue rd=4: lat 3 then lat 1, observed through dut_b
    cyc(); set_id(1, 0, 0, 0, 1, 4, 3);
    drain();
    cyc(); set_id(1, 0, 0, 0, 1, 4, 1);
    push("reiss_issue_b", K_CB, IDLE); drain();
    cyc(); set_id(1, 4, 0, 0, 0, 0, 1);
    push("reiss_cnt1_b", K_CB, STALL); push("reiss_cnt1_a", K_CA, IDLE); drain();
    cyc(); push("reiss_cnt0_b", K_CB, IDLE); drain();

    // mispredict under dmem_wait, r9 pending through the freeze
    cyc(); set_id(1, 0, 0, 0, 1, 9, 2);
    drain();
    cyc(); set_id(0, 0, 0, 0, 0, 0, 0); dmem_wait = 1'b1;
    push("mw_freeze0_a", K_CA, FREEZE); push("mw_freeze0_cnt", K_SA, 32'd3); drain();
    cyc(); mispredict = 1'b1;
    push("mw_freeze1_a", K_CA, FREEZE); push("mw_freeze1_b", K_CB, FREEZE); drain();
    cyc(); mispredict = 1'b0;
    push("mw_freeze2_a", K_CA, FREEZE); drain();
    cyc(); push("mw_freeze3_a", K_CA, FREEZE); drain();
    cyc(); dmem_wait = 1'b0; mispredict = 1'b1; set_id(1, 9, 0, 0, 0, 0, 1);
    push("mw_flush_a", K_CA, FLUSH); push("mw_flush_b", K_CB, FLUSH);
    push("mw_flush_cnt_a", K_SA, 32'd7); drain();
    cyc(); mispredict = 1'b0;
    push("mw_single_a", K_CA, IDLE); push("mw_hold_b", K_CB, STALL); drain();
    cyc(); set_id(0, 0, 0, 0, 0, 0, 0);
    push("mw_after_b", K_CB, IDLE); push("mw_after_cnt_b", K_SB, 32'd11); drain();

    // 20 frozen cycles: 4-bit counter saturates, 32-bit keeps going
    for (int i = 0; i < 20; i++) begin
      cyc(); dmem_wait = 1'b1;
      push("sat_freeze_a", K_CA, FREEZE);
      push("sat_cnt_a", K_SA, (7 + i > 15) ? 32'd15 : 32'(7 + i));
      push("sat_cnt_b", K_SB, 32'(11 + i));
      drain();
    end
    cyc(); dmem_wait = 1'b0;
    push("sat_end_a", K_CA, IDLE); push("sat_end_cnt_a", K_SA, 32'd15);
    push("sat_end_cnt_b", K_SB, 32'd31); drain();

    // sticky halt
    cyc(); halt = 1'b1;
    push("halt_edge_a", K_CA, IDLE); drain();
    cyc(); halt = 1'b0; mispredict = 1'b1; dmem_wait = 1'b1; set_id(1, 0, 0, 0, 1, 3, 1);
    push("halted_a", K_CA, HALTED); push("halted_b", K_CB, HALTED);
    push("halted_cnt_a", K_SA, 32'd15); push("halted_cnt_b", K_SB, 32'd31); drain();
    cyc(); mispredict = 1'b0; dmem_wait = 1'b0;
    push("halted_hold_a", K_CA, HALTED); push("halted_hold_cnt_b", K_SB, 32'd31); drain();

    // asynchronous reset mid-operation
    cyc(); RST = 1'b1;
    push("rst_ctrl_a", K_CA, IDLE); push("rst_cnt_a", K_SA, 32'd0);
    push("rst_ctrl_b", K_CB, IDLE); push("rst_cnt_b", K_SB, 32'd0); drain();
    cyc(); RST = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0);
    push("post_rst_a", K_CA, IDLE); push("post_rst_b", K_CB, IDLE); drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
